// File: rtl/stash_ring_if.sv
// stash_ring_if: sample, browse and status bundle between a producer/browser (master) and the stash (slave).
//   master drives sample_in, sample_in_valid, next_sample, prev_sample, clear
//   master reads  sample_out, sample_index, count, full, empty
interface stash_ring_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] sample_in;
    logic             sample_in_valid;
    logic             next_sample;
    logic             prev_sample;
    logic             clear;
    logic [WIDTH-1:0] sample_out;
    logic [IW-1:0]    sample_index;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    modport master (
        output sample_in, sample_in_valid, next_sample, prev_sample, clear,
        input  sample_out, sample_index, count, full, empty
    );
    modport slave (
        input  sample_in, sample_in_valid, next_sample, prev_sample, clear,
        output sample_out, sample_index, count, full, empty
    );
endinterface

// File: rtl/stash_ring.sv
// stash_ring: circular stash of the last DEPTH samples with forward/backward browsing over valid entries.
//   clk   rising-edge system clock
//   reset asynchronous active-high reset (zeroes memory and pointers)
//   bus   stash_ring_if.slave: sample_in/sample_in_valid write, next_sample/prev_sample browse,
//         clear flush; sample_out/sample_index/count/full/empty status
//   STASH_EDGE_EN defined: browse steps on request rising edges; undefined: one step per edge while held.
module stash_ring #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5
) (
    input logic         clk,
    input logic         reset,
    stash_ring_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [IW-1:0]    r_wr;
    logic [IW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic [SW-1:0]    w_sum;
    logic [IW-1:0]    w_oldest;
    logic [IW-1:0]    w_newest;
    logic [IW-1:0]    w_rd_inc;
    logic [IW-1:0]    w_rd_dec;
    logic [IW-1:0]    w_wr_inc;
    logic             w_empty;
    logic             w_full;
    logic             w_nstep;
    logic             w_pstep;
`ifdef STASH_EDGE_EN
    logic r_next_q;
    logic r_prev_q;
    assign w_nstep = bus.next_sample & ~r_next_q;
    assign w_pstep = bus.prev_sample & ~r_prev_q;
`else
    assign w_nstep = bus.next_sample;
    assign w_pstep = bus.prev_sample;
`endif
    always_comb begin
        // wr + DEPTH - count stays non-negative, so one conditional subtract gives the modulo
        w_sum    = SW'(r_wr) + SW'(DEPTH) - SW'(r_count);
        w_oldest = IW'(w_sum >= SW'(DEPTH) ? w_sum - SW'(DEPTH) : w_sum);
        w_newest = r_wr == '0 ? IW'(DEPTH - 1) : r_wr - IW'(1);
        w_rd_inc = r_rd == IW'(DEPTH - 1) ? '0 : r_rd + IW'(1);
        w_rd_dec = r_rd == '0 ? IW'(DEPTH - 1) : r_rd - IW'(1);
        w_wr_inc = r_wr == IW'(DEPTH - 1) ? '0 : r_wr + IW'(1);
        w_empty  = r_count == '0;
        w_full   = r_count == CW'(DEPTH);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
`ifdef STASH_EDGE_EN
            r_next_q <= 1'b0;
            r_prev_q <= 1'b0;
`endif
        end else begin
`ifdef STASH_EDGE_EN
            r_next_q <= bus.clear ? 1'b0 : bus.next_sample;
            r_prev_q <= bus.clear ? 1'b0 : bus.prev_sample;
`endif
            if (bus.clear) begin
                r_wr    <= '0;
                r_rd    <= '0;
                r_count <= '0;
            end else if (bus.sample_in_valid) begin
                r_mem[r_wr] <= bus.sample_in;
                r_rd        <= r_wr;
                r_wr        <= w_wr_inc;
                r_count     <= w_full ? r_count : r_count + CW'(1);
            end else if (!w_empty && (w_nstep ^ w_pstep)) begin
                // wrap between oldest and newest so unwritten slots are never shown
                r_rd <= w_nstep ? (r_rd == w_newest ? w_oldest : w_rd_inc)
                                : (r_rd == w_oldest ? w_newest : w_rd_dec);
            end
        end
    end
    assign bus.sample_out   = w_empty ? '0 : r_mem[r_rd];
    assign bus.sample_index = r_rd;
    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
endmodule

// File: tb/tb_stash_ring.sv
// tb_stash_ring: directed self-checking bench for stash_ring (WIDTH=8, DEPTH=5), level or edge browse mode.
module tb_stash_ring;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    stash_ring_if #(.WIDTH(8), .DEPTH(5)) bus ();
    stash_ring #(.WIDTH(8), .DEPTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask
    task automatic wr(input logic [7:0] v);
        bus.sample_in       = v;
        bus.sample_in_valid = 1'b1;
        step();
        bus.sample_in_valid = 1'b0;
    endtask
    task automatic pulse_next();
        bus.next_sample = 1'b1;
        step();
        bus.next_sample = 1'b0;
    endtask
    task automatic pulse_prev();
        bus.prev_sample = 1'b1;
        step();
        bus.prev_sample = 1'b0;
    endtask
    initial begin
        logic [7:0] fwd [5];
        logic [7:0] bwd [5];
        logic [2:0] held [4];
        n_checks = 0;
        n_errors = 0;
        bus.sample_in       = '0;
        bus.sample_in_valid = 1'b0;
        bus.next_sample     = 1'b0;
        bus.prev_sample     = 1'b0;
        bus.clear           = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_out", bus.sample_out, 0);
        chk("rst_idx", bus.sample_index, 0);
        chk("rst_cnt", bus.count, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_empty", bus.empty, 1);
        // full-buffer walk: 7 writes overwrite the two oldest
        for (int i = 0; i < 7; i++) begin
            wr(8'(i));
            chk("walk_wr", bus.sample_out, i);
        end
        chk("walk_cnt", bus.count, 5);
        chk("walk_full", bus.full, 1);
        chk("walk_idx", bus.sample_index, 1);
        chk("walk_out", bus.sample_out, 6);
        fwd = '{2, 3, 4, 5, 6};
        for (int i = 0; i < 5; i++) begin
            pulse_next();
            chk("walk_next", bus.sample_out, fwd[i]);
            step();
        end
        bwd = '{5, 4, 3, 2, 6};
        for (int i = 0; i < 5; i++) begin
            pulse_prev();
            chk("walk_prev", bus.sample_out, bwd[i]);
            step();
        end
        // partial fill
        do_reset();
        step();
        wr(10);
        wr(11);
        wr(12);
        chk("part_cnt", bus.count, 3);
        chk("part_out", bus.sample_out, 12);
        chk("part_full", bus.full, 0);
        pulse_next();
        chk("part_next", bus.sample_out, 10);
        chk("part_nidx", bus.sample_index, 0);
        step();
        pulse_prev();
        chk("part_prev", bus.sample_out, 12);
        chk("part_pidx", bus.sample_index, 2);
        step();
        // held next for 4 cycles
`ifdef STASH_EDGE_EN
        held = '{0, 0, 0, 0};
`else
        held = '{0, 1, 2, 0};
`endif
        bus.next_sample = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("held_idx", bus.sample_index, held[i]);
        end
        bus.next_sample = 1'b0;
        step();
        chk("held_out", bus.sample_out, 10);
        // clear mid-browse
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("clr_empty", bus.empty, 1);
        chk("clr_cnt", bus.count, 0);
        chk("clr_out", bus.sample_out, 0);
        step();
        pulse_next();
        chk("clr_nidx", bus.sample_index, 0);
        chk("clr_nout", bus.sample_out, 0);
        step();
        wr(7);
        chk("clr_wout", bus.sample_out, 7);
        chk("clr_widx", bus.sample_index, 0);
        chk("clr_wcnt", bus.count, 1);
        pulse_next();
        chk("one_idx", bus.sample_index, 0);
        step();
        pulse_prev();
        chk("one_pidx", bus.sample_index, 0);
        step();
        wr(8);
        chk("pre_idx", bus.sample_index, 1);
        // async reset between edges
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out", bus.sample_out, 0);
        chk("arst_idx", bus.sample_index, 0);
        chk("arst_cnt", bus.count, 0);
        chk("arst_empty", bus.empty, 1);
        chk("arst_full", bus.full, 0);
        reset = 1'b0;
        step();
        // collisions
        wr(1);
        wr(2);
        bus.next_sample = 1'b1;
        wr(9);
        bus.next_sample = 1'b0;
        chk("col_out", bus.sample_out, 9);
        chk("col_idx", bus.sample_index, 2);
        chk("col_cnt", bus.count, 3);
        step();
        chk("col_hold", bus.sample_index, 2);
        bus.next_sample = 1'b1;
        bus.prev_sample = 1'b1;
        step();
        bus.next_sample = 1'b0;
        bus.prev_sample = 1'b0;
        chk("both_idx", bus.sample_index, 2);
        chk("both_out", bus.sample_out, 9);
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
